// File: rtl/demux_router.sv
// N-channel registered demux, addressed (sel) or round-robin steering; DEMUX_ROUTER_BROADCAST_EN adds a broadcast input.
// Latency: 1 cycle from accepted input to channel output register.
// Backpressure: in_ready drops when the target channel is full and not draining; out-of-range words are dropped and counted.
module demux_router #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          data_in,
  input  logic [SEL_W-1:0]          sel,
`ifdef DEMUX_ROUTER_BROADCAST_EN
  input  logic                      broadcast,
`endif
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]          rr_ptr,
  output logic [7:0]                drop_cnt
);

  localparam logic [SEL_W:0]   CH_LIM  = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] PTR_MAX = SEL_W'(CHANNELS - 1);

  logic                bcast;
  logic [SEL_W-1:0]    tgt;
  logic                in_range;
  logic [CHANNELS-1:0] free;
  logic                tgt_free;
  logic                xfer;
  logic [CHANNELS-1:0] load;

`ifdef DEMUX_ROUTER_BROADCAST_EN
  assign bcast = broadcast;
`else
  assign bcast = 1'b0;
`endif

  assign tgt      = mode ? rr_ptr : sel;
  assign in_range = {1'b0, tgt} < CH_LIM;
  // A full channel still counts as free when its consumer takes the word this cycle.
  assign free     = ~out_valid | out_ready;

  always_comb begin
    tgt_free = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (tgt == SEL_W'(i)) tgt_free = free[i];
    end
  end

  always_comb begin
    in_ready = 1'b0;
    if (rst_n && enable) begin
      if (bcast) in_ready = &free;
      else       in_ready = in_range ? tgt_free : 1'b1;
    end
  end

  assign xfer = in_valid & in_ready;

  always_comb begin
    load = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      load[i] = xfer & (bcast | (in_range & (tgt == SEL_W'(i))));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load[i]) begin
          out_valid[i]               <= 1'b1;
          out_data[i*WIDTH +: WIDTH] <= data_in;
        end else if (out_valid[i] && out_ready[i]) begin
          out_valid[i]               <= 1'b0;
          out_data[i*WIDTH +: WIDTH] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      drop_cnt <= '0;
    end else if (xfer && !bcast) begin
      if (mode) rr_ptr <= (rr_ptr == PTR_MAX) ? '0 : rr_ptr + 1'b1;
      if (!in_range && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux_router.sv
// Directed bench for demux_router: a 4-channel instance for routing/flow control and a 3-channel one for drops.
module tb_demux_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, mode, in_valid, in_ready;
  logic [3:0]  data_in;
  logic [1:0]  sel;
  logic [3:0]  out_valid, out_ready;
  logic [15:0] out_data;
  logic [1:0]  rr_ptr;
  logic [7:0]  drop_cnt;
`ifdef DEMUX_ROUTER_BROADCAST_EN
  logic        broadcast;
`endif

  logic        b_enable, b_mode, b_in_valid, b_in_ready;
  logic [3:0]  b_data_in;
  logic [1:0]  b_sel;
  logic [2:0]  b_out_valid, b_out_ready;
  logic [11:0] b_out_data;
  logic [1:0]  b_rr_ptr;
  logic [7:0]  b_drop_cnt;
`ifdef DEMUX_ROUTER_BROADCAST_EN
  logic        b_broadcast;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  demux_router #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .sel(sel),
`ifdef DEMUX_ROUTER_BROADCAST_EN
    .broadcast(broadcast),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rr_ptr(rr_ptr), .drop_cnt(drop_cnt)
  );

  demux_router #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .enable(b_enable), .mode(b_mode),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in), .sel(b_sel),
`ifdef DEMUX_ROUTER_BROADCAST_EN
    .broadcast(b_broadcast),
`endif
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .rr_ptr(b_rr_ptr), .drop_cnt(b_drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst_n = 1'b0; enable = 1'b0; mode = 1'b0; in_valid = 1'b0;
    data_in = '0; sel = '0; out_ready = '0;
    b_enable = 1'b0; b_mode = 1'b0; b_in_valid = 1'b0;
    b_data_in = '0; b_sel = '0; b_out_ready = '0;
`ifdef DEMUX_ROUTER_BROADCAST_EN
    broadcast = 1'b0; b_broadcast = 1'b0;
`endif
    tick(); tick();
    check("reset_valid", out_valid, 4'b0000);
    check("reset_data", out_data, 16'h0000);
    check("reset_rr", rr_ptr, 2'd0);
    check("reset_drop", drop_cnt, 8'd0);

    // load channel 0, then assert reset mid-cycle
    rst_n = 1'b1; enable = 1'b1; in_valid = 1'b1; sel = 2'd0; data_in = 4'h7;
    tick();
    check("pre_rst_valid", out_valid, 4'b0001);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 4'b0000);
    check("midrst_data", out_data, 16'h0000);
    check("midrst_rdy", in_ready, 1'b0);
    tick();
    rst_n = 1'b1;

    // addressed routing
    sel = 2'd2; data_in = 4'hA; in_valid = 1'b1;
    #1;
    check("addr_rdy", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("addr_valid", out_valid, 4'b0100);
    check("addr_data", out_data, 16'h0A00);

    // backpressure on channel 1
    sel = 2'd1; data_in = 4'h3; in_valid = 1'b1;
    #1;
    check("bp_rdy1", in_ready, 1'b1);
    tick();
    data_in = 4'h9;
    #1;
    check("bp_rdy2", in_ready, 1'b0);
    tick();
    check("bp_hold_valid", out_valid, 4'b0110);
    check("bp_hold_data", out_data, 16'h0A30);
    out_ready = 4'b0010;
    #1;
    check("bp_rdy_drain", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_reload_valid", out_valid, 4'b0110);
    check("bp_reload_data", out_data, 16'h0A90);
    tick();
    check("bp_drain_valid", out_valid, 4'b0100);
    check("bp_drain_data", out_data, 16'h0A00);
    out_ready = 4'b1111;
    tick();
    check("flush_valid", out_valid, 4'b0000);

    // round robin, all consumers ready
    mode = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      data_in = 4'(k);
      #1;
      check("rr_ptr", rr_ptr, 32'((k - 1) % 4));
      check("rr_rdy", in_ready, 1'b1);
      tick();
      check("rr_valid", out_valid, 32'(1 << ((k - 1) % 4)));
      check("rr_data", out_data, 32'(k << (4 * ((k - 1) % 4))));
    end
    in_valid = 1'b0;
    check("rr_ptr_end", rr_ptr, 2'd2);
    tick();
    check("rr_flush", out_valid, 4'b0000);

    // enable gating with channel 0 full
    mode = 1'b0; sel = 2'd0; data_in = 4'h6; in_valid = 1'b1; out_ready = 4'b0000;
    tick();
    check("en_fill", out_valid, 4'b0001);
    enable = 1'b0; mode = 1'b1; out_ready = 4'b0001;
    #1;
    check("en_rdy", in_ready, 1'b0);
    tick();
    check("en_drain_valid", out_valid, 4'b0000);
    check("en_drain_data", out_data, 16'h0000);
    check("en_rr_hold", rr_ptr, 2'd2);
    in_valid = 1'b0; enable = 1'b1; mode = 1'b0;

    // out-of-range drops on the 3-channel instance
    b_enable = 1'b1; b_mode = 1'b0; b_sel = 2'd3; b_data_in = 4'hF; b_in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (i == 10) check("drop_mid", b_drop_cnt, 8'd10);
      if (b_in_ready !== 1'b1 || b_out_valid !== 3'b000) bad++;
      tick();
    end
    b_in_valid = 1'b0;
    check("drop_flow", bad, 0);
    check("drop_sat", b_drop_cnt, 8'd255);
    check("drop_rr", b_rr_ptr, 2'd0);

`ifdef DEMUX_ROUTER_BROADCAST_EN
    sel = 2'd3; data_in = 4'hC; in_valid = 1'b1; out_ready = 4'b0000;
    tick();
    check("bc_fill", out_valid, 4'b1000);
    broadcast = 1'b1; mode = 1'b1; data_in = 4'h5; out_ready = 4'b0111;
    #1;
    check("bc_rdy_blocked", in_ready, 1'b0);
    tick();
    check("bc_blocked_data", out_data, 16'hC000);
    out_ready = 4'b1111;
    #1;
    check("bc_rdy", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; broadcast = 1'b0;
    check("bc_valid", out_valid, 4'b1111);
    check("bc_data", out_data, 16'h5555);
    check("bc_rr_hold", rr_ptr, 2'd2);
    check("bc_drop_hold", drop_cnt, 8'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_router.md
# demux_router

Registered, parametrised N-channel demultiplexer with valid/ready handshaking on the input and on every output channel. Each channel has a one-entry output register, and a data word is steered either by an explicit select or by an internal round-robin pointer. The block replaces the fixed four-way combinational demux in the data-distribution path, where the consumers can stall.

## Interface
Parameters:
- WIDTH, default 4: data word width in bits.
- CHANNELS, default 4: number of output channels. Allowed range is 2..16.
- SEL_W, default 2: select width. Must satisfy 2**SEL_W >= CHANNELS.

Ports (name, direction, width, meaning):
- clk, input, 1: the single clock. All state changes on the rising edge.
- rst_n, input, 1: reset. Asynchronous assert, active-low.
- enable, input, 1: global enable. When low, no input transfer is accepted.
- mode, input, 1: steering mode. 0 means addressed by sel; 1 means round-robin.
- in_valid, input, 1: the input word is valid.
- in_ready, output, 1: the block accepts the input word this cycle.
- data_in, input, WIDTH: input word.
- sel, input, SEL_W: target channel, used only when mode is 0.
- out_valid, output, CHANNELS: per-channel valid. Bit i belongs to channel i.
- out_ready, input, CHANNELS: per-channel consumer ready.
- out_data, output, CHANNELS*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- rr_ptr, output, SEL_W: current round-robin pointer.
- drop_cnt, output, 8: count of words dropped because sel was out of range.

## Operation
- Target channel t:
  - mode 0: t = sel.
  - mode 1: t = rr_ptr.
- Channel i is free when out_valid[i] is 0, or when out_valid[i] and out_ready[i] are both 1 in the same cycle (pass-through drain).
- Input ready: in_ready = enable AND (t is free, OR t >= CHANNELS).
- A transfer occurs when in_valid and in_ready are both 1.
- Transfer with t < CHANNELS: the channel t register loads data_in and out_valid[t] goes to 1.
- Transfer with t >= CHANNELS (out of range; possible only in mode 0): the word is discarded and drop_cnt increments. drop_cnt saturates at 255.
- Round-robin: rr_ptr advances only on a mode-1 transfer, wrapping from CHANNELS-1 to 0. It holds its value in mode 0 and across mode changes.
- Channel drain: out_valid[i] and out_ready[i] both 1 with no reload that cycle clears out_valid[i] and sets that channel's out_data to 0.
- Simultaneous drain and reload on the same channel: the new word is loaded and out_valid stays 1.
- Output data: each channel's out_data is 0 whenever its out_valid is 0.
- enable low:
  - in_ready is 0.
  - Outputs continue to drain normally.
  - rr_ptr and drop_cnt hold.
- in_ready may depend combinationally on out_ready, sel, mode and enable. No output depends combinationally on data_in.

## Timing
- Reset values: out_valid = 0, out_data = 0, rr_ptr = 0, drop_cnt = 0.
- in_ready is 0 while rst_n is low.
- An rst_n assertion mid-operation clears all channel registers immediately. Pending words are lost.
- Latency: a word accepted at edge k appears on out_data/out_valid of its channel after edge k, i.e. 1 cycle.
- Throughput: one word per cycle when the target channel is being drained or is empty.
- A single channel that is held stalled does not block transfers to other channels.
- In mode 1, a stalled channel blocks the input whenever rr_ptr points at it (strict rotation, no skipping).

## Configuration
- Macro: DEMUX_ROUTER_BROADCAST_EN.
- Defined: the block adds an input port `broadcast`, 1 bit.
  - When broadcast is 1, t is ignored.
  - in_ready = enable AND every channel is free.
  - On a transfer, all channels load data_in and all out_valid bits go to 1.
  - rr_ptr and drop_cnt do not change.
- Undefined: the port is absent and the behaviour is exactly as described above.

## Test plan
- Reset and addressed routing:
  - Assert rst_n low mid-stream: all outputs read 0.
  - Then apply WIDTH=4, CHANNELS=4, mode 0, sel=2, data_in=0xA, in_valid=1, enable=1.
  - Required: after one edge, out_valid=0100, channel 2 data=0xA, other channels 0.
- Backpressure:
  - Hold out_ready[1]=0 and send two words to sel=1.
  - Required: the first is accepted, then in_ready=0 for the second. Raising out_ready[1] drains 1st and loads 2nd in the same cycle, with out_valid[1] staying 1.
- Round-robin:
  - mode 1, all out_ready=1, send 0x1 through 0x6.
  - Required: channels receive 0x1/0x2/0x3/0x4 in order, then 0x5 lands on channel 0. rr_ptr goes 0,1,2,3,0,1,2.
- Out-of-range drop:
  - CHANNELS=3, SEL_W=2, sel=3, send 300 words.
  - Required: in_ready=1 throughout, no out_valid asserted, drop_cnt=255.
- Enable gating:
  - enable=0 with in_valid=1 and channel 0 full with out_ready[0]=1.
  - Required: in_ready=0, channel 0 drains to valid 0 / data 0, rr_ptr unchanged.
- Broadcast (macro defined):
  - broadcast=1, data_in=0x5, channel 3 stalled and full.
  - Required: in_ready=0. After channel 3 drains, all four channels hold 0x5.
